fp_div_mant: RTL and testbench



---
 rtl/fp_div_pkg.sv | 18 +
 rtl/FA.sv | 13 +
 rtl/sub_25bit.sv | 26 ++
 rtl/fp_div_mant.sv | 130 +++++++++++++
 tb/tb_fp_div_mant.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fp_div_pkg.sv
// Shared constants and state encoding for the mantissa divider.
package fp_div_pkg;

  localparam int unsigned MW = 24;              // mantissa width incl. hidden bit
  localparam int unsigned QW = MW + 2;          // quotient width and iteration count
  localparam int unsigned RW = MW + 1;          // partial remainder width
  localparam int unsigned CW = $clog2(QW);      // iteration counter width

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Quotient reported for a zero divisor.
  localparam logic [QW-1:0] QuotDivZero = '1;

endpackage

// File: rtl/FA.sv
// One-bit full adder cell.
module FA (
  input  logic in1,
  input  logic in2,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = in1 ^ in2 ^ cin;
  assign cout = (in1 & in2) | (cin & (in1 ^ in2));

endmodule

// File: rtl/sub_25bit.sv
// 25-bit ripple subtractor: D = in1 - in2 as in1 + ~in2 + 1. Cout = 1 means no borrow.
module sub_25bit
  import fp_div_pkg::*;
(
  input  logic [RW-1:0] in1,
  input  logic [RW-1:0] in2,
  output logic [RW-1:0] D,
  output logic          Cout
);

  logic [RW:0] carry;

  assign carry[0] = 1'b1;
  assign Cout     = carry[RW];

  for (genvar i = 0; i < RW; i++) begin : g_fa
    FA u_fa (
      .in1  (in1[i]),
      .in2  (~in2[i]),
      .cin  (carry[i]),
      .sum  (D[i]),
      .cout (carry[i+1])
    );
  end

endmodule

// File: rtl/fp_div_mant.sv
// Restoring mantissa divider, one quotient bit per clock, MSB first.
// Optional build macro FP_DIV_EARLY_TERM_EN: finish as soon as the partial remainder is zero.
module fp_div_mant
  import fp_div_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [MW-1:0] dividend,
  input  logic [MW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quotient,
  output logic          sticky,
  output logic          div_by_zero
);

  state_e        state_q, state_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [MW-1:0] dsr_q, dsr_d;
  logic [QW-1:0] quot_q, quot_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sticky_q, sticky_d;
  logic          dbz_q, dbz_d;

  logic [RW-1:0] diff;
  logic [RW-1:0] rem_next;
  logic          no_borrow;
  logic          last_iter;

  sub_25bit u_sub (
    .in1  (rem_q),
    .in2  ({1'b0, dsr_q}),
    .D    (diff),
    .Cout (no_borrow)
  );

  // Restore by keeping R when the trial subtraction borrows; R < 2B so no bit is lost.
  assign rem_next = no_borrow ? (diff << 1) : (rem_q << 1);

`ifdef FP_DIV_EARLY_TERM_EN
  assign last_iter = (cnt_q == '0) || (rem_next == '0);
`else
  assign last_iter = (cnt_q == '0);
`endif

  // Next-state, datapath updates and status outputs.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    dsr_d    = dsr_q;
    quot_d   = quot_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    dbz_d    = dbz_q;
    busy     = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          rem_d    = {1'b0, dividend};
          dsr_d    = divisor;
          quot_d   = '0;
          cnt_d    = CW'(QW - 1);
          sticky_d = 1'b0;
          dbz_d    = 1'b0;
          if (divisor == '0) begin
            quot_d  = QuotDivZero;
            dbz_d   = 1'b1;
            // Counter doubles as a one-cycle hold so done lands where early termination would.
            cnt_d   = CW'(1);
            state_d = StDone;
          end else begin
            state_d = StRun;
          end
        end
      end

      StRun: begin
        busy          = 1'b1;
        quot_d[cnt_q] = no_borrow;
        rem_d         = rem_next;
        cnt_d         = cnt_q - CW'(1);
        if (last_iter) begin
          sticky_d = |rem_next;
          cnt_d    = '0;
          state_d  = StDone;
        end
      end

      StDone: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rem_q    <= '0;
      dsr_q    <= '0;
      quot_q   <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      dsr_q    <= dsr_d;
      quot_q   <= quot_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      dbz_q    <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign sticky      = sticky_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp_div_mant.sv
// Self-checking bench for fp_div_mant: directed table, random vectors against an arithmetic
// model, and an abort-by-reset sequence.
module tb_fp_div_mant;

  localparam int QW = 26;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] dividend = '0;
  logic [23:0] divisor = '0;
  logic        busy, done, sticky, div_by_zero;
  logic [25:0] quotient;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_div_mant dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .sticky      (sticky),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [25:0] q;
    logic        st;
    logic        dz;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Quotient = floor(A * 2^(QW-1) / B); latency from the position of the first zero remainder.
  function automatic void model(input logic [23:0] a, input logic [23:0] b,
                                output logic [25:0] q, output logic st, output logic dz,
                                output int lat);
    longint unsigned num, den;
    if (b == 0) begin
      q = '1; st = 1'b0; dz = 1'b1; lat = 2;
      return;
    end
    num = longint'(a) << (QW - 1);
    den = longint'(b);
    q   = 26'(num / den);
    st  = (num % den) != 0;
    dz  = 1'b0;
    lat = QW + 1;
`ifdef FP_DIV_EARLY_TERM_EN
    for (int j = 1; j <= QW; j++) begin
      if (((longint'(a) << (j - 1)) % den) == 0) begin
        lat = j + 1;
        break;
      end
    end
`endif
  endfunction

  task automatic run_div(input logic [23:0] a, input logic [23:0] b, input logic [25:0] q_e,
                         input logic st_e, input logic dz_e, input int lat_e, input string tag);
    int lat, nbusy;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat   = 0;
    nbusy = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        lat = n;
        break;
      end
    end
    check({tag, ".latency"}, 64'(lat), 64'(lat_e));
    check({tag, ".busy_cycles"}, 64'(nbusy), dz_e ? 64'd0 : 64'(lat_e - 1));
    check({tag, ".quotient"}, 64'(quotient), 64'(q_e));
    check({tag, ".sticky"}, 64'(sticky), 64'(st_e));
    check({tag, ".div_by_zero"}, 64'(div_by_zero), 64'(dz_e));
    @(negedge clk);
    check({tag, ".done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    logic [23:0] a, b;
    logic [25:0] q_e;
    logic        st_e, dz_e;
    int          lat_e, ndone, nbusy;

    vecs[0] = '{a: 24'h800000, b: 24'h800000, q: 26'h2000000, st: 1'b0, dz: 1'b0};
    vecs[1] = '{a: 24'hC00000, b: 24'h800000, q: 26'h3000000, st: 1'b0, dz: 1'b0};
    vecs[2] = '{a: 24'h800000, b: 24'hC00000, q: 26'h1555555, st: 1'b1, dz: 1'b0};
    vecs[3] = '{a: 24'h800000, b: 24'h000000, q: 26'h3FFFFFF, st: 1'b0, dz: 1'b1};
    vecs[4] = '{a: 24'hFFFFFF, b: 24'h800000, q: 26'h3FFFFFC, st: 1'b0, dz: 1'b0};
    vecs[5] = '{a: 24'h800000, b: 24'hFFFFFF, q: 26'h1000001, st: 1'b1, dz: 1'b0};

    // Asynchronous reset values.
    #1;
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.quotient", 64'(quotient), 64'd0);
    check("reset.sticky", 64'(sticky), 64'd0);
    check("reset.div_by_zero", 64'(div_by_zero), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      model(vecs[i].a, vecs[i].b, q_e, st_e, dz_e, lat_e);
      run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].st, vecs[i].dz, lat_e,
              $sformatf("vec%0d", i));
    end

    // The last result holds while idle.
    run_div(24'h800000, 24'hC00000, 26'h1555555, 1'b1, 1'b0, QW + 1, "hold_src");
    repeat (3) @(negedge clk);
    check("hold.quotient", 64'(quotient), 64'h1555555);
    check("hold.sticky", 64'(sticky), 64'd1);
    check("hold.q_msb", 64'(quotient[25]), 64'd0);

    // Randomized normalised mantissas.
    for (int i = 0; i < 40; i++) begin
      a = 24'h800000 | 24'($urandom);
      b = 24'h800000 | 24'($urandom);
      if (i % 8 == 0) b = 24'h800000 | (24'($urandom) & 24'hF00000);
      model(a, b, q_e, st_e, dz_e, lat_e);
      run_div(a, b, q_e, st_e, dz_e, lat_e, $sformatf("rnd%0d", i));
    end

    // Start while busy is ignored; reset mid-run aborts without a done.
    @(negedge clk);
    dividend = 24'h800000;
    divisor  = 24'hC00000;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (done) ndone++;
      if (n == 5) begin
        dividend = 24'h123456;
        divisor  = 24'h000000;
        start    = 1'b1;
      end
      if (n == 6) begin
        start = 1'b0;
        check("ignore.busy", 64'(busy), 64'd1);
        check("ignore.div_by_zero", 64'(div_by_zero), 64'd0);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.done", 64'(done), 64'd0);
    check("abort.quotient", 64'(quotient), 64'd0);
    check("abort.sticky", 64'(sticky), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    nbusy = 0;
    for (int n = 0; n < 35; n++) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) nbusy++;
    end
    check("abort.no_done", 64'(ndone), 64'd0);
    check("abort.idle", 64'(nbusy), 64'd0);

    model(24'h800000, 24'h800000, q_e, st_e, dz_e, lat_e);
    run_div(24'h800000, 24'h800000, 26'h2000000, 1'b0, 1'b0, lat_e, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
